survivor_readout: RTL
=====================

# survivor_readout

Reader side of the Viterbi survivor shift memory. Captures the eight 32-bit column words the shift memory presents one per cycle, and double-buffers each completed 8-column frame. For the best-metric state supplied by the ACS compare stage, it extracts that state's 8-bit decision history and serializes it, oldest bit first, on a valid/ready stream to the decoded-bit sink.

## Interface
- NUM_COL, 8, columns per frame (one word per cycle)
- WORD_W, 32, column word width; 4 states x 8 history bits
- DEPTH, 8, history bits per state
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- mem_data  in  32  current column word from shift memory
- col_sync  in  1  high when mem_data is column 0
- frame_en  in  1  capture enable, sampled at frame start
- best_state  in  5  survivor state, sampled on column-7 cycle
- dec_bit  out  1  decoded bit
- dec_valid  out  1  dec_bit valid
- dec_ready  in  1  sink accepts dec_bit
- ovf  out  1  one-cycle pulse: completed frame dropped, no free buffer
- sync_err  out  1  one-cycle pulse: col_sync seen mid-frame
- busy  out  1  capture in progress or any buffer full

## Operation
- State s maps to column s>>2, bits [8*(s&3)+7 : 8*(s&3)] of that column's word; bit 7 is the oldest decision.
- Storage: two frame buffers A and B, each 8x32, each with a full flag. wr_ptr selects the capture target; rd_ptr selects the output source. Both pointers reset to A.
- Capture FSM, states CAP_IDLE and CAP_RUN, with col_cnt 0..7:
  - CAP_IDLE: on col_sync & frame_en, store the column-0 word, set col_cnt=1, go to CAP_RUN.
  - Frame start also evaluates the target buffer. If the target is full and is not being released this cycle, the frame is marked discard: no writes occur, and ovf pulses at the column-7 cycle.
  - CAP_RUN: store the word at col_cnt and increment.
  - On col_cnt==7, store the word and latch best_state into the buffer's state register. Set the full flag, toggle wr_ptr, and return to CAP_IDLE.
  - If col_sync occurs while col_cnt is 1..7, pulse sync_err and abandon the partial frame. That same cycle is treated as a new frame start.
  - frame_en is ignored after frame start.
- Output FSM, states OUT_IDLE and OUT_SEND, with bit_idx 7..0:
  - OUT_IDLE: when buffer[rd_ptr] is full, load bit_idx=7 and go to OUT_SEND.
  - OUT_SEND: dec_valid=1 and dec_bit = history[bit_idx] of the latched state.
  - On dec_valid & dec_ready, decrement bit_idx.
  - On acceptance of bit 0, clear the full flag and toggle rd_ptr. If the other buffer is full, stay in OUT_SEND with bit_idx=7 (no bubble); otherwise go to OUT_IDLE.
- dec_bit and dec_valid hold stable while dec_ready is low.
- Simultaneous events:
  - A buffer released by the output in the same cycle a frame starts targeting it counts as free.
  - A full flag set in the same cycle the output FSM is idle is seen on the next cycle.
- busy = (capture FSM in CAP_RUN) | fullA | fullB.

## Timing
- Reset values: dec_bit=0, dec_valid=0, ovf=0, sync_err=0, busy=0; both buffers empty, both FSMs idle, pointers = A.
- Reset mid-frame or mid-output discards all buffered data immediately.
- With col_sync at cycle T, column 7 arrives at T+7, the full flag is set at T+8, and dec_valid rises at T+9.
- Output throughput is one bit per cycle while dec_ready=1. A frame drains in 8 accepted cycles, which matches the 8-cycle frame rate.
- ovf and sync_err are registered single-cycle pulses, asserted the cycle after the triggering edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Single frame: column 1 word = 0x0000A500, best_state=5, dec_ready=1 -> dec_bit sequence 1,0,1,0,0,1,0,1 with dec_valid high for exactly cycles T+9..T+16.
- Back-to-back frames with best_state=0 (column 0 words 0xFF, 0x00) and dec_ready=1 -> sixteen contiguous valid cycles, eight 1s then eight 0s, no gaps; ovf never asserted.
- Backpressure: dec_ready toggles 1,0,0,1,... -> dec_bit is held during stalls and all 8 bits arrive in order.
- Overflow: dec_ready=0 while three frames are sent -> the third frame raises a 1-cycle ovf pulse. After releasing dec_ready, exactly 16 bits are emitted, from frames 1 and 2.
- Resync: col_sync reasserted at col_cnt=4 -> 1-cycle sync_err pulse. The next 8 columns form a frame that decodes correctly.
- Reset asserted after 3 output bits -> all outputs are 0 next edge, busy=0. After release, a fresh frame decodes normally.

Source files
------------

// File: rtl/survivor_readout.sv
// Viterbi survivor readout: captures 8-column frames into two ping-pong
// buffers and streams the best state's decision history oldest bit first.
module survivor_readout #(
  parameter int NUM_COL = 8,
  parameter int WORD_W  = 32,
  parameter int DEPTH   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] mem_data,
  input  logic              col_sync,
  input  logic              frame_en,
  input  logic [4:0]        best_state,
  output logic              dec_bit,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic              ovf,
  output logic              sync_err,
  output logic              busy
);

  localparam int CW = $clog2(NUM_COL);
  localparam int BW = $clog2(DEPTH);
  localparam int LW = $clog2(WORD_W / DEPTH);

  typedef enum logic {CAP_IDLE, CAP_RUN} cap_e;
  typedef enum logic {OUT_IDLE, OUT_SEND} out_e;

  cap_e            cap_q;
  out_e            out_q;
  logic [CW-1:0]   col_cnt_q;
  logic            disc_q;
  logic            wr_q;
  logic            rd_q;
  logic [1:0]      full_q;
  logic [BW-1:0]   bit_idx_q;
  logic            dec_bit_q;
  logic            dec_valid_q;
  logic            ovf_q;
  logic            sync_err_q;

  logic [WORD_W-1:0] mem_q [2][NUM_COL];
  logic [4:0]        st_q  [2];

  logic          release_d;
  logic          start_d;
  logic          free_d;
  logic          last_d;
  logic          wr_en_d;
  logic [CW-1:0] wr_col_d;

  always_comb begin
    release_d = (out_q == OUT_SEND) && dec_ready && (bit_idx_q == '0);
    start_d   = col_sync && frame_en;
    // A buffer drained on this very edge is free for a new frame
    free_d    = !full_q[wr_q] || (release_d && (rd_q == wr_q));
    last_d    = (cap_q == CAP_RUN) && !col_sync &&
                (col_cnt_q == CW'(NUM_COL - 1));
    wr_en_d   = (start_d && free_d) ||
                ((cap_q == CAP_RUN) && !col_sync && !disc_q);
    wr_col_d  = start_d ? '0 : col_cnt_q;
  end

  logic [4:0]        st_cur;
  logic [4:0]        st_oth;
  logic [WORD_W-1:0] w_cur;
  logic [WORD_W-1:0] w_oth;
  logic [DEPTH-1:0]  h_cur;
  logic [DEPTH-1:0]  h_oth;

  always_comb begin
    st_cur = st_q[rd_q];
    st_oth = st_q[~rd_q];
    w_cur  = mem_q[rd_q][st_cur[4:LW]];
    w_oth  = mem_q[~rd_q][st_oth[4:LW]];
    h_cur  = w_cur[int'(st_cur[LW-1:0]) * DEPTH +: DEPTH];
    h_oth  = w_oth[int'(st_oth[LW-1:0]) * DEPTH +: DEPTH];
  end

  always_ff @(posedge clk) begin
    if (wr_en_d) mem_q[wr_q][wr_col_d] <= mem_data;
    if (last_d && !disc_q) st_q[wr_q] <= best_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q       <= CAP_IDLE;
      out_q       <= OUT_IDLE;
      col_cnt_q   <= '0;
      disc_q      <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      full_q      <= '0;
      bit_idx_q   <= '0;
      dec_bit_q   <= 1'b0;
      dec_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      ovf_q      <= 1'b0;
      sync_err_q <= 1'b0;

      unique case (cap_q)
        CAP_IDLE: begin
          if (start_d) begin
            cap_q     <= CAP_RUN;
            col_cnt_q <= CW'(1);
            disc_q    <= !free_d;
          end
        end
        CAP_RUN: begin
          if (col_sync) begin
            sync_err_q <= 1'b1;
            if (frame_en) begin
              col_cnt_q <= CW'(1);
              disc_q    <= !free_d;
            end else begin
              cap_q <= CAP_IDLE;
            end
          end else if (last_d) begin
            cap_q <= CAP_IDLE;
            if (disc_q) begin
              ovf_q <= 1'b1;
            end else begin
              full_q[wr_q] <= 1'b1;
              wr_q         <= ~wr_q;
            end
          end else begin
            col_cnt_q <= col_cnt_q + 1'b1;
          end
        end
        default: cap_q <= CAP_IDLE;
      endcase

      unique case (out_q)
        OUT_IDLE: begin
          if (full_q[rd_q]) begin
            out_q       <= OUT_SEND;
            bit_idx_q   <= BW'(DEPTH - 1);
            dec_valid_q <= 1'b1;
            dec_bit_q   <= h_cur[DEPTH-1];
          end
        end
        OUT_SEND: begin
          if (dec_ready) begin
            if (bit_idx_q != '0) begin
              bit_idx_q <= bit_idx_q - 1'b1;
              dec_bit_q <= h_cur[bit_idx_q - 1'b1];
            end else begin
              full_q[rd_q] <= 1'b0;
              rd_q         <= ~rd_q;
              if (full_q[~rd_q]) begin
                bit_idx_q <= BW'(DEPTH - 1);
                dec_bit_q <= h_oth[DEPTH-1];
              end else begin
                out_q       <= OUT_IDLE;
                dec_valid_q <= 1'b0;
                dec_bit_q   <= 1'b0;
              end
            end
          end
        end
        default: out_q <= OUT_IDLE;
      endcase
    end
  end

  assign dec_bit   = dec_bit_q;
  assign dec_valid = dec_valid_q;
  assign ovf       = ovf_q;
  assign sync_err  = sync_err_q;
  assign busy      = (cap_q == CAP_RUN) | full_q[0] | full_q[1];

endmodule
